uart_tx_param: RTL and testbench

Parametrised UART transmitter for the programmable-logic lab designs. It accepts words over a valid/ready handshake into a small internal FIFO and serialises each one as a frame: start bit, DATA_BITS data bits LSB first, an optional parity bit, then STOP_BITS stop bits. Each frame carries its own parity mode. This block replaces the fixed 8-bit single-shot transmitter. Button debouncing and one-shot generation are not part of this block; upstream logic drives `tx_valid`.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_param_if.sv | 15 +
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_tx_param.sv | 143 ++++++++++++++
 tb/tb_uart_tx_param.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity encodings and baud helper
package uart_pkg;

    typedef logic [1:0] par_t;

    localparam par_t PAR_NONE = 2'd0;
    localparam par_t PAR_ODD  = 2'd1;
    localparam par_t PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Truncating division; the receiver derives its sample timing from the same value.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// rtl/uart_tx_param_if.sv - word handshake into the UART transmitter FIFO
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    import uart_pkg::*;

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    par_t                 parity_type;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, output parity_type, input tx_ready);
    modport slave  (input tx_valid, input tx_data, input parity_type, output tx_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - parametrised synchronous FIFO with push/pop/full/empty
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - FIFO-fed UART transmitter with per-frame parity mode
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    uart_tx_param_if.slave s_tx,
    output logic           o_tx_serial,
    output logic           o_tx_busy,
    output logic           o_tx_done
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int IW  = $clog2(DATA_BITS);
    localparam int EW  = DATA_BITS + 2;

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_PARITY = ST_PARITY;
    localparam logic [2:0] S_STOP   = ST_STOP;

    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en;
    logic                 r_par_bit;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_frame_end;
    logic [EW-1:0]        w_head;
    par_t                 w_head_par;
    logic [DATA_BITS-1:0] w_head_data;

    assign s_tx.tx_ready = !w_full;
    assign {w_head_par, w_head_data} = w_head;
    assign w_bit_end   = (r_cnt == CW'(CPB - 1));
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_stop_idx == 1'(STOP_BITS - 1));
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_frame_end);

    uart_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (s_tx.tx_valid),
        .i_wdata ({s_tx.parity_type, s_tx.tx_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            o_tx_serial <= 1'b1;
            o_tx_busy   <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            r_cnt     <= w_bit_end ? '0 : r_cnt + CW'(1);

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state     <= S_DATA;
                        r_idx       <= '0;
                        o_tx_serial <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_idx != IW'(DATA_BITS - 1)) begin
                            r_idx       <= r_idx + IW'(1);
                            r_shift     <= r_shift >> 1;
                            o_tx_serial <= r_shift[1];
                        end else if (r_par_en) begin
                            r_state     <= S_PARITY;
                            o_tx_serial <= r_par_bit;
                        end else begin
                            r_state     <= S_STOP;
                            r_stop_idx  <= 1'b0;
                            o_tx_serial <= 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state     <= S_STOP;
                        r_stop_idx  <= 1'b0;
                        o_tx_serial <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_frame_end) begin
                        o_tx_done <= 1'b1;
                        r_state   <= S_IDLE;
                        o_tx_busy <= 1'b0;
                    end else if (w_bit_end) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A pop overrides the IDLE fall-back so back-to-back frames have no gap.
            if (w_pop) begin
                r_state     <= S_START;
                r_cnt       <= '0;
                r_shift     <= w_head_data;
                r_par_en    <= (w_head_par == PAR_ODD) || (w_head_par == PAR_EVEN);
                r_par_bit   <= (w_head_par == PAR_EVEN) ? ^w_head_data : ~^w_head_data;
                o_tx_serial <= 1'b0;
                o_tx_busy   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - scoreboard bench for uart_tx_param
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int CPB = 10;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v   = 1'b0;
    logic [8:0] d   = '0;
    logic [1:0] p   = '0;
    logic       sel = 1'b0;

    logic ser_a, busy_a, done_a, ser_b, busy_b, done_b;
    logic m_ser, m_busy, m_done, m_ready;

    int cyc         = 0;
    int n_chk       = 0;
    int n_fail      = 0;
    int done_cnt    = 0;
    bit mon_en      = 1'b0;
    bit in_frame    = 1'b0;

    frame_t exp_q[$];
    int     start_q[$];
    int     done_q[$];
    int     len_q[$];

    uart_tx_param_if #(.DATA_BITS(8)) if_a ();
    uart_tx_param_if #(.DATA_BITS(7)) if_b ();

    assign if_a.tx_valid    = v && !sel;
    assign if_a.tx_data     = d[7:0];
    assign if_a.parity_type = p;
    assign if_b.tx_valid    = v && sel;
    assign if_b.tx_data     = d[6:0];
    assign if_b.parity_type = p;

    assign m_ser   = sel ? ser_b  : ser_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_ready = sel ? if_b.tx_ready : if_a.tx_ready;

    uart_tx_param #(
        .CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .s_tx(if_a),
        .o_tx_serial(ser_a), .o_tx_busy(busy_a), .o_tx_done(done_a)
    );

    uart_tx_param #(
        .CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .s_tx(if_b),
        .o_tx_serial(ser_b), .o_tx_busy(busy_b), .o_tx_done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mon_en && m_done === 1'b1) done_cnt++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Frame as the line should carry it: start, data LSB first, optional parity, stop bits.
    function automatic frame_t model(input logic [8:0] data, input logic [1:0] par, input int nd, input int ns);
        frame_t f;
        int k    = 0;
        int ones = 0;
        f.bits = '0;
        f.bits[k] = 1'b0; k++;
        for (int i = 0; i < nd; i++) begin
            f.bits[k] = data[i]; k++;
            ones += int'(data[i]);
        end
        if (par == 2'd1 || par == 2'd2) begin
            if (par == 2'd2) f.bits[k] = (ones % 2) == 1;
            else             f.bits[k] = (ones % 2) == 0;
            k++;
        end
        for (int i = 0; i < ns; i++) begin
            f.bits[k] = 1'b1; k++;
        end
        f.n = k;
        return f;
    endfunction

    task automatic send(input logic [8:0] data, input logic [1:0] par, output int acc_cyc);
        int t  = 0;
        int nd = sel ? 7 : 8;
        int ns = sel ? 2 : 1;
        v = 1'b1; d = data; p = par;
        while (m_ready !== 1'b1 && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 3000) fail_now("send_ready");
        @(posedge clk); #1;
        acc_cyc = cyc;
        exp_q.push_back(model(data, par, nd, ns));
        v = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || in_frame || m_busy !== 1'b0) && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 5000) fail_now("drain");
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        frame_t f;
        bit carry = 1'b0;
        bit aborted;
        int bad_k;
        logic bad_ser, bad_busy, bad_done;
        forever begin
            if (!carry) @(negedge clk);
            carry = 1'b0;
            if (mon_en && m_ser === 1'b0) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_frame");
                    for (int t = 0; t < 200 && m_ser !== 1'b1; t++) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    in_frame = 1'b1;
                    start_q.push_back(cyc);
                    len_q.push_back(f.n);
                    bad_k = -1; aborted = 1'b0;
                    bad_ser = 1'b0; bad_busy = 1'b0; bad_done = 1'b0;
                    for (int k = 0; k < f.n * CPB; k++) begin
                        if (k != 0) @(negedge clk);
                        if (!mon_en) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (bad_k < 0 && (m_ser !== f.bits[k / CPB] || m_busy !== 1'b1 ||
                                          (k != 0 && m_done !== 1'b0))) begin
                            bad_k = k; bad_ser = m_ser; bad_busy = m_busy; bad_done = m_done;
                        end
                    end
                    if (!aborted) @(negedge clk);
                    if (aborted || !mon_en) begin
                        done_q.push_back(-1);
                    end else begin
                        n_chk++;
                        if (bad_k >= 0) begin
                            n_fail++;
                            $display("FAIL frame_bits: start %0d offset %0d got ser=%b busy=%b done=%b, expected ser=%b busy=1 done=0",
                                     start_q[$], bad_k, bad_ser, bad_busy, bad_done, f.bits[bad_k / CPB]);
                        end
                        chk("done_pulse", m_done, 1);
                        done_q.push_back(cyc);
                        carry = 1'b1;
                    end
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #600_000;
        $display("FAIL global_timeout: run exceeded its cycle budget");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int acc[6];
        int base;
        int dc;
        int s;
        int t;
        logic [8:0] rd;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_serial_a", ser_a, 1);
        chk("rst_ready_a", if_a.tx_ready, 1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_serial_b", ser_b, 1);
        chk("rst_ready_b", if_b.tx_ready, 1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single 8N1 frame, pop latency and done timing
        base = start_q.size();
        send(9'h0A5, 2'd0, acc[0]);
        wait_drain();
        chk("t1_pop_latency", start_q[base] - acc[0], 1);
        chk("t1_done_at", done_q[base] - start_q[base], 100);
        chk("t1_busy_idle", m_busy, 0);

        // Odd then even parity
        base = start_q.size();
        send(9'h007, 2'd1, acc[0]);
        wait_drain();
        send(9'h007, 2'd2, acc[1]);
        wait_drain();
        chk("t2_odd_len", done_q[base] - start_q[base], 110);
        chk("t2_even_len", done_q[base+1] - start_q[base+1], 110);

        // Six back-to-back words through a 4-deep FIFO
        base = start_q.size();
        dc   = done_cnt;
        for (int i = 0; i < 6; i++) begin
            send(9'($urandom), 2'($urandom_range(3, 0)), acc[i]);
            if (i == 4) chk("t3_ready_low_after_5", m_ready, 0);
        end
        wait_drain();
        chk("t3_first_pop", start_q[base] - acc[0], 1);
        chk("t3_word6_after_pop", acc[5] - start_q[base+1], 1);
        for (int k = 0; k < 5; k++)
            chk("t3_contiguous", start_q[base+k+1] - start_q[base+k], len_q[base+k] * CPB);
        chk("t3_done_count", done_cnt - dc, 6);

        // Reset during data bit 3 with two words queued
        base = start_q.size();
        for (int i = 0; i < 3; i++) send(9'($urandom), 2'd0, acc[i]);
        t = 0;
        while (start_q.size() <= base && t < 500) begin @(posedge clk); #1; t++; end
        if (t >= 500) fail_now("t4_start");
        s = (start_q.size() > base) ? start_q[base] : cyc;
        t = 0;
        while (cyc < s + 44 && t < 500) begin @(posedge clk); #1; t++; end
        mon_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t4_serial", ser_a, 1);
        chk("t4_ready", if_a.tx_ready, 1);
        chk("t4_busy", busy_a, 0);
        dc = done_cnt;
        mon_en = 1'b1;
        repeat (300) @(negedge clk);
        chk("t4_no_done", done_cnt - dc, 0);
        chk("t4_no_frames", start_q.size() - base, 1);
        @(posedge clk); #1;

        // 7 data bits, 2 stop bits, even parity, then random traffic
        sel = 1'b1;
        base = start_q.size();
        send(9'h055, 2'd2, acc[0]);
        wait_drain();
        chk("t5_len", done_q[base] - start_q[base], 110);
        for (int i = 0; i < 8; i++) begin
            send(9'($urandom), 2'($urandom_range(3, 0)), acc[0]);
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
        end
        wait_drain();

        // Mode 3 behaves as no parity
        sel = 1'b0;
        @(posedge clk); #1;
        rd = 9'($urandom);
        base = start_q.size();
        send(rd, 2'd3, acc[0]);
        wait_drain();
        send(rd, 2'd0, acc[1]);
        wait_drain();
        chk("t6_mode3_len", done_q[base] - start_q[base], 100);
        chk("t6_mode0_len", done_q[base+1] - start_q[base+1], 100);

        // Random words with random gaps
        for (int i = 0; i < 16; i++) begin
            send(9'($urandom), 2'($urandom_range(3, 0)), acc[0]);
            repeat ($urandom_range(120, 0)) begin @(posedge clk); #1; end
        end
        wait_drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
